scale_factor_ctrl: RTL and testbench
====================================

# scale_factor_ctrl

Request-side controller for the scale-factor calculator. It accepts fundamental-frequency estimates from the pitch detector and presents each one to the calculator as a held request with its valid level. It captures the returned scale factor and drives a slew-limited playback scale to the resampler. It sits between the pitch detector and the resampler, and owns the calculator's `fundamental`/`fundamental_valid` inputs and its `factor`/`factor_valid` outputs.

## Interface
- `FUNDAMENTAL_WIDTH`, 38: fundamental width, unsigned 16Q21.
- `SCALE_WIDTH`, 24: scale width, unsigned 2Q21.
- `TIMEOUT_CYCLES`, 128: maximum cycles in REQUEST without a factor.
- `SLEW_STEP`, 24'h000800: maximum change of `scale` per `sample_tick`, in 2Q21 LSBs.
- `DRAIN_CYCLES`, 2: cycles `sf_fundamental_valid` stays low between requests.

- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `est_fundamental` in `FUNDAMENTAL_WIDTH`: estimate from the pitch detector.
- `est_valid` in 1: estimate strobe; accepted only when `est_valid & est_ready`.
- `est_ready` out 1: high in IDLE.
- `sf_fundamental` out `FUNDAMENTAL_WIDTH`: held request value to the calculator.
- `sf_fundamental_valid` out 1: request level; high for the whole of REQUEST.
- `sf_factor` in `SCALE_WIDTH`: calculator result.
- `sf_factor_valid` in 1: calculator result valid; stays high while the request is held.
- `sample_tick` in 1: one-cycle audio-rate strobe that advances the slew.
- `scale` out `SCALE_WIDTH`: slew-limited scale to the resampler.
- `scale_settled` out 1: `scale == target`.
- `timeout_err` out 1: one-cycle pulse on a request timeout.

## Operation
- States:
  - IDLE: `est_ready = 1`. On accept:
    - If `est_fundamental == 0`: `target <= 24'h200000` (1.0) and stay in IDLE.
    - Otherwise: latch `sf_fundamental <= est_fundamental`, clear the timeout counter, go to REQUEST.
  - REQUEST: `sf_fundamental_valid = 1` and `sf_fundamental` is held constant. On the first cycle with `sf_factor_valid = 1`:
    - If `sf_factor != 0`: `target <= sf_factor`.
    - If `sf_factor == 0`: `target` is unchanged.
    - Go to DRAIN.
  - Timeout: if the counter reaches `TIMEOUT_CYCLES - 1` without `sf_factor_valid`, pulse `timeout_err`, leave `target` unchanged, go to DRAIN.
  - DRAIN: `sf_fundamental_valid = 0` for exactly `DRAIN_CYCLES`, so the calculator's internal enable and note counter clear. Then go to IDLE.
- An `est_valid` that arrives outside IDLE is dropped. There is no queueing.
- If `sf_factor_valid` arrives while in IDLE or DRAIN, it is ignored.
- Slew, applied on each `sample_tick`, using `d = target - scale` (signed, `SCALE_WIDTH+1` bits):
  - If `|d| <= SLEW_STEP`: `scale <= target`.
  - Otherwise: `scale <= scale ± SLEW_STEP` toward `target`.
  - The step never overshoots, and no underflow or overflow of the unsigned 2Q21 range is possible.
- `target` update and `sample_tick` in the same cycle: the slew uses the old `target`, and the new `target` takes effect from the next tick.
- `scale_settled` is combinational from registered `scale` and `target`.

## Timing
- Reset values (asynchronous):
  - state = IDLE, so `est_ready = 1` while in reset.
  - `sf_fundamental = 0`, `sf_fundamental_valid = 0`.
  - `target = scale = 24'h200000`, `scale_settled = 1`.
  - `timeout_err = 0`, timeout counter = 0.
- Accept on cycle N: `sf_fundamental_valid` is high from cycle N+1, and `est_ready` is low from N+1.
- Factor captured at cycle M, the first cycle in which `sf_factor_valid` is seen high: `target` updates at M+1, and `sf_fundamental_valid` is low from M+1.
- The calculator responds roughly 78 cycles after the request rises (64-note sweep plus a 14-cycle pipeline). `TIMEOUT_CYCLES` must exceed this.
- Back-to-back request spacing is at least `DRAIN_CYCLES + 1` cycles from capture to the next `sf_fundamental_valid` rise.
- Reset mid-REQUEST: `sf_fundamental_valid` drops asynchronously, the factor is discarded, and `scale` returns to 1.0 immediately.
- All outputs are registered except `est_ready` and `scale_settled`, which are decoded from registered state.

## Test plan
- **Normal request:** `est_fundamental = 440.0` (0x37000000) with `est_valid`; stub asserts `sf_factor_valid` with `sf_factor = 0x1C0000` after 78 cycles. Required: request held 78 cycles, `target = 0x1C0000`, valid low for 2 cycles, then `est_ready` high.
- **Slew:** from `scale = 0x200000`, `target = 0x1C0000`, `SLEW_STEP = 0x800`. Required: 128 ticks to settle; `scale_settled` rises on the 128th tick; no overshoot.
- **Timeout:** stub never responds. Required: `timeout_err` pulses once on cycle 128 of REQUEST, `target` unchanged, return to IDLE after DRAIN.
- **Zero inputs:** `est_fundamental = 0` gives `target = 0x200000` with no request issued. A separate request answered with `sf_factor = 0` leaves `target` unchanged.
- **Busy/stale handling:** `est_valid` pulsed during REQUEST and DRAIN is dropped, and exactly one request is seen. A stuck-high `sf_factor_valid` during DRAIN causes no recapture.
- **Reset mid-operation:** assert `reset_n = 0` 40 cycles into REQUEST, with `scale` mid-slew. Required: all reset values appear immediately, and after release a new accept works.

Source files
------------

// File: rtl/scale_factor_ctrl_if.sv
// rtl/scale_factor_ctrl_if.sv - estimate input and calculator request/response signals
interface scale_factor_ctrl_if #(
   parameter int FUNDAMENTAL_WIDTH = 38,
   parameter int SCALE_WIDTH       = 24
);
   // pitch detector -> controller
   logic [FUNDAMENTAL_WIDTH-1:0] est_fundamental;
   logic                         est_valid;
   logic                         est_ready;
   // controller <-> scale-factor calculator
   logic [FUNDAMENTAL_WIDTH-1:0] sf_fundamental;
   logic                         sf_fundamental_valid;
   logic [SCALE_WIDTH-1:0]       sf_factor;
   logic                         sf_factor_valid;

   // controller side
   modport master (
      input  est_fundamental,
      input  est_valid,
      output est_ready,
      output sf_fundamental,
      output sf_fundamental_valid,
      input  sf_factor,
      input  sf_factor_valid
   );

   // pitch detector / calculator side
   modport slave (
      output est_fundamental,
      output est_valid,
      input  est_ready,
      input  sf_fundamental,
      input  sf_fundamental_valid,
      output sf_factor,
      output sf_factor_valid
   );
endinterface

// File: rtl/scale_factor_ctrl.sv
// rtl/scale_factor_ctrl.sv - request-side controller and slew-limited playback scale
module scale_factor_ctrl #(
   parameter int                     FUNDAMENTAL_WIDTH = 38,
   parameter int                     SCALE_WIDTH       = 24,
   parameter int                     TIMEOUT_CYCLES    = 128,
   parameter logic [SCALE_WIDTH-1:0] SLEW_STEP         = 24'h000800,
   parameter int                     DRAIN_CYCLES      = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   scale_factor_ctrl_if.master    bus,
   input  logic                   sample_tick,
   output logic [SCALE_WIDTH-1:0] scale,
   output logic                   scale_settled,
   output logic                   timeout_err
);

   // 1.0 in unsigned 2Q21
   localparam logic [SCALE_WIDTH-1:0] SCALE_ONE = SCALE_WIDTH'(32'h0020_0000);

   // one counter serves both the request timeout and the drain gap
   localparam int CNT_MAX = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQUEST = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [CNT_W-1:0]             r_cnt;
   logic [FUNDAMENTAL_WIDTH-1:0] r_sf_fundamental;
   logic                         r_sf_valid;
   logic [SCALE_WIDTH-1:0]       r_target;
   logic [SCALE_WIDTH-1:0]       r_scale;
   logic                         r_timeout_err;

   logic                         w_est_ready;
   logic                         w_accept_zero;
   logic                         w_accept_req;
   logic                         w_capture;
   logic                         w_timeout;
   logic [SCALE_WIDTH:0]         w_diff;
   logic [SCALE_WIDTH:0]         w_mag;
   logic [SCALE_WIDTH-1:0]       w_scale_nxt;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode and the one-cycle events that steer the datapath
   always_comb begin
      w_state_nxt   = r_state;
      w_est_ready   = 1'b0;
      w_accept_zero = 1'b0;
      w_accept_req  = 1'b0;
      w_capture     = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_est_ready = 1'b1;
            if (bus.est_valid) begin
               if (bus.est_fundamental == '0) begin
                  w_accept_zero = 1'b1;
               end else begin
                  w_accept_req = 1'b1;
                  w_state_nxt  = S_REQUEST;
               end
            end
         end
         S_REQUEST: begin
            if (bus.sf_factor_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DRAIN;
            end else if (r_cnt == TO_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_cnt == DRAIN_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // request register, target register, shared counter and timeout pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sf_fundamental <= '0;
         r_sf_valid       <= 1'b0;
         r_target         <= SCALE_ONE;
         r_cnt            <= '0;
         r_timeout_err    <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;

         if (w_accept_req) begin
            r_sf_fundamental <= bus.est_fundamental;
            r_sf_valid       <= 1'b1;
         end else if (w_capture || w_timeout) begin
            r_sf_valid <= 1'b0;
         end

         // a zero estimate means no pitch: fall back to unity playback
         if (w_accept_zero) begin
            r_target <= SCALE_ONE;
         end else if (w_capture && (bus.sf_factor != '0)) begin
            r_target <= bus.sf_factor;
         end

         if (w_accept_req || w_capture || w_timeout) begin
            r_cnt <= '0;
         end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // distance to target and the clamped one-step move toward it
   always_comb begin
      w_diff = {1'b0, r_target} - {1'b0, r_scale};
      w_mag  = w_diff[SCALE_WIDTH] ? (~w_diff + 1'b1) : w_diff;
      if (w_mag <= {1'b0, SLEW_STEP}) begin
         w_scale_nxt = r_target;
      end else if (w_diff[SCALE_WIDTH]) begin
         w_scale_nxt = r_scale - SLEW_STEP;
      end else begin
         w_scale_nxt = r_scale + SLEW_STEP;
      end
   end

   // playback scale advances only on the audio-rate tick
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_scale <= SCALE_ONE;
      end else if (sample_tick) begin
         r_scale <= w_scale_nxt;
      end
   end

   assign bus.est_ready            = w_est_ready;
   assign bus.sf_fundamental       = r_sf_fundamental;
   assign bus.sf_fundamental_valid = r_sf_valid;
   assign scale                    = r_scale;
   assign scale_settled            = (r_scale == r_target);
   assign timeout_err              = r_timeout_err;

endmodule

// File: tb/tb_scale_factor_ctrl.sv
// tb/tb_scale_factor_ctrl.sv - randomized self-checking bench for scale_factor_ctrl
module tb_scale_factor_ctrl;
   localparam int FW   = 38;
   localparam int SW   = 24;
   localparam int STEP = 'h800;
   localparam int ONE  = 'h200000;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          sample_tick = 1'b0;
   logic [SW-1:0] scale;
   logic          scale_settled;
   logic          timeout_err;

   int n_checks = 0;
   int n_pass   = 0;
   int m_target = ONE;
   int m_scale  = ONE;

   scale_factor_ctrl_if #(.FUNDAMENTAL_WIDTH(FW), .SCALE_WIDTH(SW)) bus ();

   scale_factor_ctrl #(
      .FUNDAMENTAL_WIDTH(FW),
      .SCALE_WIDTH      (SW),
      .TIMEOUT_CYCLES   (128),
      .SLEW_STEP        (24'h000800),
      .DRAIN_CYCLES     (2)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .bus          (bus),
      .sample_tick  (sample_tick),
      .scale        (scale),
      .scale_settled(scale_settled),
      .timeout_err  (timeout_err)
   );

   always #5 clock = ~clock;

   // reference slew: move toward target by at most STEP, landing exactly when close
   function automatic int slew(input int s, input int t);
      int d;
      d = t - s;
      if (d <= STEP && d >= -STEP) return t;
      if (d > 0) return s + STEP;
      return s - STEP;
   endfunction

   // one clock with an optional tick; the tick uses the target in force before this edge
   task automatic clk_step(input bit tick);
      sample_tick = tick;
      if (tick) m_scale = slew(m_scale, m_target);
      @(posedge clock);
      #1;
      sample_tick = 1'b0;
   endtask

   task automatic accept(input logic [FW-1:0] f);
      bus.est_fundamental = f;
      bus.est_valid       = 1'b1;
      clk_step(1'b0);
      bus.est_valid       = 1'b0;
   endtask

   task automatic settle(input string name);
      int k;
      k = 0;
      while (scale_settled !== 1'b1 && k < 4000) begin
         clk_step(1'b1);
         k++;
      end
      n_checks++;
      if (scale !== SW'(m_target) || scale_settled !== 1'b1)
         $display("FAIL %s: scale %h settled %b, expected %h settled 1", name, scale, scale_settled, SW'(m_target));
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (bus.est_ready !== 1'b1 || bus.sf_fundamental_valid !== 1'b0 || bus.sf_fundamental !== '0)
         $display("FAIL reset_request: ready %b valid %b fund %h, expected 1 0 0",
                  bus.est_ready, bus.sf_fundamental_valid, bus.sf_fundamental);
      else n_pass++;
      n_checks++;
      if (scale !== SW'(ONE) || scale_settled !== 1'b1 || timeout_err !== 1'b0)
         $display("FAIL reset_scale: scale %h settled %b err %b, expected 200000 1 0",
                  scale, scale_settled, timeout_err);
      else n_pass++;
      reset_n  = 1'b1;
      m_target = ONE;
      m_scale  = ONE;
      clk_step(1'b0);
   endtask

   task automatic test_normal();
      int held;
      accept(38'h0037000000);
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b1 || bus.est_ready !== 1'b0)
         $display("FAIL normal_accept: valid %b ready %b, expected 1 0", bus.sf_fundamental_valid, bus.est_ready);
      else n_pass++;
      held = 1;
      for (int i = 1; i < 78; i++) begin
         clk_step(1'b0);
         if (bus.sf_fundamental_valid === 1'b1 && bus.sf_fundamental === 38'h0037000000) held++;
      end
      bus.sf_factor       = 24'h1C0000;
      bus.sf_factor_valid = 1'b1;
      clk_step(1'b0);
      m_target            = 'h1C0000;
      bus.sf_factor_valid = 1'b0;
      n_checks++;
      if (held !== 78) $display("FAIL normal_hold: held %0d cycles, expected 78", held);
      else n_pass++;
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b0 || bus.est_ready !== 1'b0 || scale_settled !== 1'b0)
         $display("FAIL normal_capture: valid %b ready %b settled %b, expected 0 0 0",
                  bus.sf_fundamental_valid, bus.est_ready, scale_settled);
      else n_pass++;
      clk_step(1'b0);
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b0 || bus.est_ready !== 1'b0)
         $display("FAIL normal_drain: valid %b ready %b, expected 0 0", bus.sf_fundamental_valid, bus.est_ready);
      else n_pass++;
      clk_step(1'b0);
      n_checks++;
      if (bus.est_ready !== 1'b1) $display("FAIL normal_idle: ready %b, expected 1", bus.est_ready);
      else n_pass++;
   endtask

   task automatic test_slew();
      int settle_at;
      settle_at = 0;
      for (int k = 1; k <= 200 && settle_at == 0; k++) begin
         clk_step(1'b1);
         n_checks++;
         if (scale !== SW'(m_scale)) $display("FAIL slew_track: tick %0d scale %h, expected %h", k, scale, SW'(m_scale));
         else n_pass++;
         if (scale_settled === 1'b1) settle_at = k;
         clk_step(1'b0);
      end
      n_checks++;
      if (settle_at !== 128 || scale !== 24'h1C0000)
         $display("FAIL slew_settle: settled on tick %0d at %h, expected tick 128 at 1c0000", settle_at, scale);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int  held, pulses;
      bit  dropped;
      logic err_at_drop, ready_d2, ready_idle;
      accept(FW'({$urandom(), $urandom()}) | FW'(1));
      held = 1; pulses = 0; dropped = 0; err_at_drop = 1'b0;
      for (int i = 0; i < 300 && !dropped; i++) begin
         clk_step(1'b0);
         if (timeout_err === 1'b1) pulses++;
         if (bus.sf_fundamental_valid === 1'b1) held++;
         else begin
            dropped     = 1;
            err_at_drop = timeout_err;
         end
      end
      clk_step(1'b0);
      ready_d2 = bus.est_ready;
      if (timeout_err === 1'b1) pulses++;
      clk_step(1'b0);
      ready_idle = bus.est_ready;
      for (int i = 0; i < 8; i++) begin
         if (timeout_err === 1'b1) pulses++;
         clk_step(1'b0);
      end
      n_checks++;
      if (held !== 128 || err_at_drop !== 1'b1)
         $display("FAIL timeout_cycle: held %0d err %b, expected 128 1", held, err_at_drop);
      else n_pass++;
      n_checks++;
      if (pulses !== 1) $display("FAIL timeout_pulses: %0d pulses, expected 1", pulses);
      else n_pass++;
      n_checks++;
      if (ready_d2 !== 1'b0 || ready_idle !== 1'b1)
         $display("FAIL timeout_drain: ready %b then %b, expected 0 then 1", ready_d2, ready_idle);
      else n_pass++;
      n_checks++;
      if (scale !== SW'(m_target) || scale_settled !== 1'b1)
         $display("FAIL timeout_target: scale %h settled %b, expected %h 1", scale, scale_settled, SW'(m_target));
      else n_pass++;
   endtask

   task automatic test_zero();
      accept('0);
      m_target = ONE;
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b0 || bus.est_ready !== 1'b1 || scale_settled !== 1'b0)
         $display("FAIL zero_est: valid %b ready %b settled %b, expected 0 1 0",
                  bus.sf_fundamental_valid, bus.est_ready, scale_settled);
      else n_pass++;
      settle("zero_est_target");
      accept(38'h0012345678);
      repeat (9) clk_step(1'b0);
      bus.sf_factor       = '0;
      bus.sf_factor_valid = 1'b1;
      clk_step(1'b0);
      bus.sf_factor_valid = 1'b0;
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b0 || scale_settled !== 1'b1)
         $display("FAIL zero_factor: valid %b settled %b, expected 0 1", bus.sf_fundamental_valid, scale_settled);
      else n_pass++;
      clk_step(1'b0);
      clk_step(1'b0);
      settle("zero_factor_target");
   endtask

   task automatic test_busy_stale();
      int   rises;
      bit   held_ok;
      logic prev;
      logic [FW-1:0] f1, f2;
      f1 = 38'h0A5A5A5A5;
      f2 = 38'h3000000001;
      accept(f1);
      rises = (bus.sf_fundamental_valid === 1'b1) ? 1 : 0;
      prev = bus.sf_fundamental_valid;
      held_ok = 1;
      for (int c = 2; c <= 30; c++) begin
         bus.est_valid       = (c == 3 || c == 4 || c == 20);
         bus.est_fundamental = f2;
         clk_step(1'b0);
         bus.est_valid = 1'b0;
         if (bus.sf_fundamental_valid === 1'b1 && prev !== 1'b1) rises++;
         if (bus.sf_fundamental_valid === 1'b1 && bus.sf_fundamental !== f1) held_ok = 0;
         prev = bus.sf_fundamental_valid;
      end
      bus.sf_factor       = 24'h1A0000;
      bus.sf_factor_valid = 1'b1;
      clk_step(1'b0);
      m_target      = 'h1A0000;
      bus.sf_factor = 24'h260000;
      prev = bus.sf_fundamental_valid;
      for (int c = 0; c < 12; c++) begin
         bus.est_valid = (c < 2);
         clk_step(1'b0);
         bus.est_valid = 1'b0;
         if (bus.sf_fundamental_valid === 1'b1 && prev !== 1'b1) rises++;
         prev = bus.sf_fundamental_valid;
      end
      bus.sf_factor_valid = 1'b0;
      n_checks++;
      if (rises !== 1) $display("FAIL busy_requests: %0d requests, expected 1", rises);
      else n_pass++;
      n_checks++;
      if (held_ok !== 1'b1) $display("FAIL busy_hold: request value changed %b, expected held 1", held_ok);
      else n_pass++;
      n_checks++;
      if (bus.est_ready !== 1'b1) $display("FAIL busy_idle: ready %b, expected 1", bus.est_ready);
      else n_pass++;
      settle("stale_factor_target");
   endtask

   task automatic test_reset_mid();
      logic [FW-1:0] f3;
      accept(38'h0001000000);
      repeat (4) clk_step(1'b0);
      bus.sf_factor       = 24'h280000;
      bus.sf_factor_valid = 1'b1;
      clk_step(1'b0);
      m_target            = 'h280000;
      bus.sf_factor_valid = 1'b0;
      clk_step(1'b0);
      clk_step(1'b0);
      accept(38'h0002000000);
      for (int i = 1; i < 40; i++) clk_step(1'b1);
      n_checks++;
      if (scale !== SW'(m_scale) || scale_settled !== 1'b0 || bus.sf_fundamental_valid !== 1'b1)
         $display("FAIL mid_slew: scale %h settled %b valid %b, expected %h 0 1",
                  scale, scale_settled, bus.sf_fundamental_valid, SW'(m_scale));
      else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b0 || bus.sf_fundamental !== '0 || bus.est_ready !== 1'b1)
         $display("FAIL async_reset_req: valid %b fund %h ready %b, expected 0 0 1",
                  bus.sf_fundamental_valid, bus.sf_fundamental, bus.est_ready);
      else n_pass++;
      n_checks++;
      if (scale !== SW'(ONE) || scale_settled !== 1'b1 || timeout_err !== 1'b0)
         $display("FAIL async_reset_scale: scale %h settled %b err %b, expected 200000 1 0",
                  scale, scale_settled, timeout_err);
      else n_pass++;
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      m_target = ONE;
      m_scale  = ONE;
      clk_step(1'b0);
      f3 = 38'h0033333333;
      accept(f3);
      n_checks++;
      if (bus.sf_fundamental_valid !== 1'b1 || bus.sf_fundamental !== f3)
         $display("FAIL post_reset_accept: valid %b fund %h, expected 1 %h", bus.sf_fundamental_valid, bus.sf_fundamental, f3);
      else n_pass++;
      repeat (2) clk_step(1'b0);
      bus.sf_factor       = 24'h180000;
      bus.sf_factor_valid = 1'b1;
      clk_step(1'b0);
      m_target            = 'h180000;
      bus.sf_factor_valid = 1'b0;
      clk_step(1'b0);
      clk_step(1'b0);
      settle("post_reset_target");
   endtask

   task automatic test_random();
      int            lat, fac, held;
      bit            zero_est;
      logic [FW-1:0] f;
      for (int t = 0; t < 14; t++) begin
         zero_est = ($urandom_range(0, 4) == 0);
         f = zero_est ? '0 : (FW'({$urandom(), $urandom()}) | FW'(1));
         bus.est_fundamental = f;
         bus.est_valid       = 1'b1;
         clk_step(1'($urandom_range(0, 1)));
         bus.est_valid = 1'b0;
         if (zero_est) begin
            m_target = ONE;
            n_checks++;
            if (bus.sf_fundamental_valid !== 1'b0 || bus.est_ready !== 1'b1)
               $display("FAIL rand_zero: valid %b ready %b, expected 0 1", bus.sf_fundamental_valid, bus.est_ready);
            else n_pass++;
         end else begin
            lat  = $urandom_range(1, 100);
            fac  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range('h100000, 'h3FFFFF));
            held = 1;
            for (int i = 1; i < lat; i++) begin
               clk_step(1'($urandom_range(0, 1)));
               if (bus.sf_fundamental_valid === 1'b1 && bus.sf_fundamental === f) held++;
            end
            bus.sf_factor       = SW'(fac);
            bus.sf_factor_valid = 1'b1;
            clk_step(1'($urandom_range(0, 1)));
            if (fac != 0) m_target = fac;
            bus.sf_factor_valid = 1'b0;
            n_checks++;
            if (held !== lat || bus.sf_fundamental_valid !== 1'b0)
               $display("FAIL rand_hold: held %0d valid %b, expected %0d 0", held, bus.sf_fundamental_valid, lat);
            else n_pass++;
            clk_step(1'($urandom_range(0, 1)));
            clk_step(1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.est_ready !== 1'b1) $display("FAIL rand_ready: ready %b, expected 1", bus.est_ready);
            else n_pass++;
         end
         n_checks++;
         if (scale !== SW'(m_scale) || scale_settled !== (m_scale == m_target))
            $display("FAIL rand_scale: scale %h settled %b, expected %h %b",
                     scale, scale_settled, SW'(m_scale), (m_scale == m_target));
         else n_pass++;
         if (t % 4 == 3) settle("rand_settle");
      end
   endtask

   initial begin
      bus.est_fundamental = '0;
      bus.est_valid       = 1'b0;
      bus.sf_factor       = '0;
      bus.sf_factor_valid = 1'b0;
      test_reset();
      test_normal();
      test_slew();
      test_timeout();
      test_zero();
      test_busy_stale();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
